// File: rtl/axis_stat_pkg.sv
// Shared types and default constants for the AXI-Stream statistics monitor.
// Optional min/max frame-length tracking is enabled with macro AXIS_STAT_MINMAX_EN.
package axis_stat_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StInFrame
    } frame_state_e;

    localparam int unsigned DefDataWidth     = 8;
    localparam int unsigned DefCountWidth    = 32;
    localparam int unsigned DefLenWidth      = 16;
    localparam int unsigned DefActHoldCycles = 1250000;

`ifdef AXIS_STAT_MINMAX_EN
    localparam bit MinMaxEn = 1'b1;
`else
    localparam bit MinMaxEn = 1'b0;
`endif

endpackage

// File: rtl/led_stretch.sv
// Pulse stretcher: led rises the cycle after trig and stays high HOLD_CYCLES cycles
// after the most recent trig; clr drops it immediately.
module led_stretch #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    input  logic clr,
    output logic led
);

    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CntW-1:0] cnt_q;
    logic            led_q;

    // The cycle in which the counter reaches zero is the last lit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else if (trig) begin
            cnt_q <= CntW'(HOLD_CYCLES - 1);
            led_q <= 1'b1;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end else begin
            led_q <= 1'b0;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/axis_stat_monitor.sv
// Passive AXI-Stream monitor: counts frames, bytes and errored frames and drives status LEDs.
// Define AXIS_STAT_MINMAX_EN to add min_len/max_len frame-length tracking.
module axis_stat_monitor
    import axis_stat_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DefDataWidth,
    parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned COUNT_WIDTH     = DefCountWidth,
    parameter int unsigned LEN_WIDTH       = DefLenWidth,
    parameter int unsigned ACT_HOLD_CYCLES = DefActHoldCycles
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEEP_WIDTH-1:0]  mon_tkeep,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tlast,
    input  logic                   mon_tuser,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] byte_count,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic [LEN_WIDTH-1:0]   last_len,
`ifdef AXIS_STAT_MINMAX_EN
    output logic [LEN_WIDTH-1:0]   min_len,
    output logic [LEN_WIDTH-1:0]   max_len,
`endif
    output logic                   act_led,
    output logic                   err_led
);

    localparam int unsigned BytesW = $clog2(KEEP_WIDTH + 1);

    logic [1:0]             rst_sync_q;
    logic                   run;
    frame_state_e           state_q;
    logic [LEN_WIDTH-1:0]   cur_len_q;
    logic [LEN_WIDTH-1:0]   last_len_q;
    logic [COUNT_WIDTH-1:0] frame_count_q;
    logic [COUNT_WIDTH-1:0] byte_count_q;
    logic [COUNT_WIDTH-1:0] error_count_q;
    logic                   err_led_q;

    logic                   beat;
    logic                   last_beat;
    logic [BytesW-1:0]      beat_bytes;
    logic [LEN_WIDTH-1:0]   len_base;
    logic [LEN_WIDTH:0]     len_sum;
    logic [LEN_WIDTH-1:0]   frame_len;

    // Beats are ignored until the released reset has passed through both sync flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + BytesW'(mon_tkeep[i]);
        end
        beat      = mon_tvalid & mon_tready & run & ~clear;
        last_beat = beat & mon_tlast;
        len_base  = (state_q == StInFrame) ? cur_len_q : '0;
        len_sum   = {1'b0, len_base} + (LEN_WIDTH + 1)'(beat_bytes);
        frame_len = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cur_len_q     <= '0;
            last_len_q    <= '0;
            frame_count_q <= '0;
            byte_count_q  <= '0;
            error_count_q <= '0;
            err_led_q     <= 1'b0;
        end else if (clear) begin
            state_q       <= StIdle;
            cur_len_q     <= '0;
            last_len_q    <= '0;
            frame_count_q <= '0;
            byte_count_q  <= '0;
            error_count_q <= '0;
            err_led_q     <= 1'b0;
        end else if (beat) begin
            byte_count_q <= byte_count_q + COUNT_WIDTH'(beat_bytes);
            if (mon_tlast) begin
                state_q    <= StIdle;
                cur_len_q  <= '0;
                last_len_q <= frame_len;
                if (frame_count_q != '1) begin
                    frame_count_q <= frame_count_q + COUNT_WIDTH'(1);
                end
                if (mon_tuser) begin
                    err_led_q <= 1'b1;
                    if (error_count_q != '1) begin
                        error_count_q <= error_count_q + COUNT_WIDTH'(1);
                    end
                end
            end else begin
                state_q   <= StInFrame;
                cur_len_q <= frame_len;
            end
        end
    end

`ifdef AXIS_STAT_MINMAX_EN
    logic [LEN_WIDTH-1:0] min_len_q;
    logic [LEN_WIDTH-1:0] max_len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_len_q <= '1;
            max_len_q <= '0;
        end else if (clear) begin
            min_len_q <= '1;
            max_len_q <= '0;
        end else if (last_beat) begin
            if (frame_len < min_len_q) begin
                min_len_q <= frame_len;
            end
            if (frame_len > max_len_q) begin
                max_len_q <= frame_len;
            end
        end
    end

    assign min_len = min_len_q;
    assign max_len = max_len_q;
`endif

    led_stretch #(
        .HOLD_CYCLES(ACT_HOLD_CYCLES)
    ) u_act_stretch (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (last_beat),
        .clr  (clear),
        .led  (act_led)
    );

    assign frame_count = frame_count_q;
    assign byte_count  = byte_count_q;
    assign error_count = error_count_q;
    assign last_len    = last_len_q;
    assign err_led     = err_led_q;

endmodule

// File: doc/axis_stat_monitor.md
AXIS_STAT_MONITOR -- requirements
Module: axis_stat_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning monitored stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, meaning tkeep width.
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, meaning width of the frame, byte and error counters.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, meaning width of the frame-length registers.
REQ-005 SHALL have parameter ACT_HOLD_CYCLES, default 1250000, meaning activity LED hold time in clk cycles (10 ms at 125 MHz).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is in this domain.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port mon_tkeep, input, KEEP_WIDTH, byte-lane valid bits of the monitored beat.
REQ-009 SHALL have ports mon_tvalid, mon_tready, mon_tlast and mon_tuser, all input, 1 bit each; they are observed only and never driven.
REQ-010 SHALL have port clear, input, 1, synchronous clear pulse for all statistics.
REQ-011 SHALL have outputs frame_count, byte_count and error_count, each COUNT_WIDTH bits.
REQ-012 SHALL have output last_len, LEN_WIDTH bits, byte length of the most recent completed frame.
REQ-013 SHALL have outputs act_led and err_led, 1 bit each, status indicators.

Function
REQ-014 A beat SHALL be defined as mon_tvalid & mon_tready in a clk cycle; no other cycle affects statistics.
REQ-015 The beat byte count SHALL be popcount(mon_tkeep); a beat with mon_tkeep of 0 SHALL count as 0 bytes but still advance frame state.
REQ-016 The frame FSM SHALL have states IDLE and IN_FRAME: a non-last beat moves to IN_FRAME, a last beat moves to IDLE, and a single-beat frame stays in IDLE.
REQ-017 cur_len SHALL accumulate beat bytes, saturate at 2^LEN_WIDTH-1, and reset to 0 after every last beat.
REQ-018 On a last beat, last_len SHALL become cur_len plus the beat bytes (saturating) and frame_count SHALL increment.
REQ-019 If mon_tuser=1 on a last beat, error_count SHALL also increment; mon_tuser on non-last beats SHALL be ignored.
REQ-020 byte_count SHALL add beat bytes every beat and wrap modulo 2^COUNT_WIDTH.
REQ-021 frame_count and error_count SHALL saturate at all-ones and never wrap.
REQ-022 All statistic outputs SHALL be registered and reflect a beat on the clk edge that ends the beat (latency 1).
REQ-023 act_led SHALL go high the cycle after any last beat, and SHALL stay high for ACT_HOLD_CYCLES cycles after the most recent last beat; a new last beat restarts the hold.
REQ-024 err_led SHALL go high the cycle after an errored last beat and SHALL hold until clear or reset.
REQ-025 clear SHALL zero all counters, last_len and cur_len, force IDLE, and drop both LEDs; a beat in the same cycle as clear SHALL be discarded.
REQ-026 After a clear mid-frame, the remaining beats of that frame SHALL be counted as a new frame.

Reset
REQ-027 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and cur_len and the hold counter SHALL be 0, asynchronously.
REQ-028 Reset deassertion SHALL be synchronised internally with a 2-flop synchroniser; the first beat counted SHALL be at or after the second clk edge after deassertion.

Configuration
REQ-029 With macro AXIS_STAT_MINMAX_EN defined, the block SHALL add outputs min_len and max_len (LEN_WIDTH bits each), updated on each last beat.
REQ-030 min_len SHALL reset and clear to all-ones; max_len SHALL reset and clear to 0.
REQ-031 Without AXIS_STAT_MINMAX_EN, those ports and their logic SHALL not exist.

Structure
REQ-032 The FSM state typedef and the default constants SHALL live in package axis_stat_pkg.
REQ-033 The LED hold timer SHALL be a sub-module, led_stretch (parameter HOLD_CYCLES; ports clk, rst_n, trig, clr, led).

Verification (DATA_WIDTH=8 unless stated)
REQ-034 Scenario 1: one 64-beat frame, last beat tuser=0 -> frame_count=1, byte_count=64, last_len=64, error_count=0, act_led=1 for ACT_HOLD_CYCLES.
REQ-035 Scenario 2: 3-beat frame with tuser=1 on the last beat -> error_count=1, err_led=1 until clear pulse, then all outputs 0.
REQ-036 Scenario 3: DATA_WIDTH=32, 2 beats with tkeep 0xF then 0x3, tready toggling -> last_len=6; cycles with tready low add nothing.
REQ-037 Scenario 4: COUNT_WIDTH=4, 17 single-beat frames -> frame_count=15 (saturated), byte_count=1 (wrapped).
REQ-038 Scenario 5: clear on beat 3 of a 5-beat frame -> last_len=2, frame_count=1; rst_n low mid-frame -> all outputs 0 immediately.
REQ-039 Scenario 6 (with AXIS_STAT_MINMAX_EN): frames of 60, 1514 and 64 bytes -> min_len=60, max_len=1514.
